issue_stage: RTL and testbench

- Dual-issue in-order issue stage, directly downstream of the frontend's decoded-instruction FIFO.
- Each cycle it inspects the two FIFO head entries and selects 0, 1 or 2 of them to issue, using a per-register busy scoreboard and intra-pair hazard checks.
- It returns the issued count to the FIFO as its read count and registers the issued instructions into a holding stage for the execute pipeline.

---
 rtl/issue_stage.sv | 131 +++++++++++++
 tb/tb_issue_stage.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_stage.sv
// Dual-issue in-order issue stage: scoreboard hazard checks plus a holding register.
// Define ISSUE_STAGE_PERF_CNT_EN to build the stall/issue performance counters.
module issue_stage #(
   parameter int PAYLOAD_W = 256,
   parameter int WB_PORTS  = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush_i,
   input  logic [1:0]                     head_valid_i,
   input  logic [1:0][4:0]                head_rs0_i,
   input  logic [1:0][4:0]                head_rs1_i,
   input  logic [1:0][4:0]                head_rd_i,
   input  logic [1:0][PAYLOAD_W-1:0]      head_payload_i,
   output logic [1:0]                     read_num_o,
   input  logic [WB_PORTS-1:0]            wb_valid_i,
   input  logic [WB_PORTS-1:0][4:0]       wb_reg_i,
   input  logic                           ex_ready_i,
   output logic [1:0]                     issue_valid_o,
   output logic [1:0][4:0]                issue_rd_o,
   output logic [1:0][PAYLOAD_W-1:0]      issue_payload_o,
   output logic [31:0]                    stall_cnt_o,
   output logic [31:0]                    issue_cnt_o
);

   logic [31:0] busy_q;
   logic [31:0] busy_d;
   logic [31:0] wb_hit;
   logic [31:0] busy_eff;
   logic [31:0] set_mask;
   logic [1:0]  src_ok;
   logic        can_acc;
   logic        raw;
   logic        waw;
   logic        go0;
   logic        go1;
   logic [1:0]  go;

   // Writebacks landing this cycle are bypassed into the hazard check.
   always_comb begin
      wb_hit = '0;
      for (int k = 0; k < WB_PORTS; k++) begin
         if (wb_valid_i[k]) wb_hit[wb_reg_i[k]] = 1'b1;
      end
      busy_eff    = busy_q & ~wb_hit;
      busy_eff[0] = 1'b0;
   end

   always_comb begin
      src_ok = '0;
      for (int s = 0; s < 2; s++) begin
         src_ok[s] = ~busy_eff[head_rs0_i[s]]
                   & ~busy_eff[head_rs1_i[s]]
                   & ~busy_eff[head_rd_i[s]];
      end
   end

   assign can_acc = ~|issue_valid_o | ex_ready_i;

   assign raw = (head_rd_i[0] != 5'd0)
              & ((head_rd_i[0] == head_rs0_i[1])
              |  (head_rd_i[0] == head_rs1_i[1]));

   assign waw = (head_rd_i[1] != 5'd0)
              & (head_rd_i[1] == head_rd_i[0]);

   assign go0 = head_valid_i[0] & can_acc & ~flush_i & ~rst & src_ok[0];
   assign go1 = go0 & head_valid_i[1] & src_ok[1] & ~raw & ~waw;
   assign go  = {go1, go0};

   assign read_num_o = {1'b0, go0} + {1'b0, go1};

   // Set wins over a same-cycle writeback clear.
   always_comb begin
      set_mask = '0;
      if (go0) set_mask[head_rd_i[0]] = 1'b1;
      if (go1) set_mask[head_rd_i[1]] = 1'b1;
      busy_d    = (busy_q & ~wb_hit) | set_mask;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         issue_valid_o   <= '0;
         issue_rd_o      <= '0;
         issue_payload_o <= '0;
      end else if (flush_i) begin
         issue_valid_o <= '0;
      end else if (can_acc) begin
         issue_valid_o <= go;
         for (int s = 0; s < 2; s++) begin
            if (go[s]) begin
               issue_rd_o[s]      <= head_rd_i[s];
               issue_payload_o[s] <= head_payload_i[s];
            end
         end
      end
   end

`ifdef ISSUE_STAGE_PERF_CNT_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] issue_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         issue_cnt_q <= '0;
      end else begin
         if (head_valid_i[0] && (read_num_o == 2'd0) && !flush_i) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         issue_cnt_q <= issue_cnt_q + {30'd0, read_num_o};
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign issue_cnt_o = issue_cnt_q;
`else
   assign stall_cnt_o = '0;
   assign issue_cnt_o = '0;
`endif

endmodule

// File: tb/tb_issue_stage.sv
// Self-checking bench for issue_stage: directed scenarios plus a randomized
// run against a queue/scoreboard reference model.
module tb_issue_stage;

   localparam int PW = 256;
   localparam int WB = 2;
`ifdef ISSUE_STAGE_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   flush_i;
   logic [1:0]             head_valid_i;
   logic [1:0][4:0]        head_rs0_i;
   logic [1:0][4:0]        head_rs1_i;
   logic [1:0][4:0]        head_rd_i;
   logic [1:0][PW-1:0]     head_payload_i;
   logic [1:0]             read_num_o;
   logic [WB-1:0]          wb_valid_i;
   logic [WB-1:0][4:0]     wb_reg_i;
   logic                   ex_ready_i;
   logic [1:0]             issue_valid_o;
   logic [1:0][4:0]        issue_rd_o;
   logic [1:0][PW-1:0]     issue_payload_o;
   logic [31:0]            stall_cnt_o;
   logic [31:0]            issue_cnt_o;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   issue_stage #(.PAYLOAD_W(PW), .WB_PORTS(WB)) dut (
      .clk             (clk),
      .rst             (rst),
      .flush_i         (flush_i),
      .head_valid_i    (head_valid_i),
      .head_rs0_i      (head_rs0_i),
      .head_rs1_i      (head_rs1_i),
      .head_rd_i       (head_rd_i),
      .head_payload_i  (head_payload_i),
      .read_num_o      (read_num_o),
      .wb_valid_i      (wb_valid_i),
      .wb_reg_i        (wb_reg_i),
      .ex_ready_i      (ex_ready_i),
      .issue_valid_o   (issue_valid_o),
      .issue_rd_o      (issue_rd_o),
      .issue_payload_o (issue_payload_o),
      .stall_cnt_o     (stall_cnt_o),
      .issue_cnt_o     (issue_cnt_o)
   );

   function automatic logic [PW-1:0] rnd_pay();
      logic [PW-1:0] p;
      for (int i = 0; i < PW / 32; i++) p[i*32 +: 32] = $urandom;
      return p;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_heads(input logic [1:0] hv,
                            input logic [4:0] a0, input logic [4:0] a1,
                            input logic [4:0] ad, input logic [4:0] b0,
                            input logic [4:0] b1, input logic [4:0] bd);
      head_valid_i      = hv;
      head_rs0_i[0]     = a0;
      head_rs1_i[0]     = a1;
      head_rd_i[0]      = ad;
      head_rs0_i[1]     = b0;
      head_rs1_i[1]     = b1;
      head_rd_i[1]      = bd;
      head_payload_i[0] = rnd_pay();
      head_payload_i[1] = rnd_pay();
   endtask

   task automatic clear_state();
      head_valid_i = 2'b00;
      wb_valid_i   = '0;
      ex_ready_i   = 1'b1;
      flush_i      = 1'b1;
      tick();
      flush_i      = 1'b0;
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      flush_i    = 1'b0;
      ex_ready_i = 1'b1;
      wb_valid_i = '0;
      wb_reg_i   = '0;
      set_heads(2'b11, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6);
      #1;
      checks++;
      if (read_num_o !== 2'd0) begin
         failures++;
         $display("FAIL reset_read_num got=%0d exp=0", read_num_o);
      end
      tick();
      checks++;
      if (issue_valid_o !== 2'b00 || issue_rd_o !== '0 || issue_payload_o !== '0) begin
         failures++;
         $display("FAIL reset_outputs got valid=%b rd=%h exp 0", issue_valid_o, issue_rd_o);
      end
      checks++;
      if (stall_cnt_o !== 32'd0 || issue_cnt_o !== 32'd0) begin
         failures++;
         $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cnt_o, issue_cnt_o);
      end
      rst = 1'b0;
   endtask

   task automatic test_pair();
      logic [PW-1:0] p0;
      logic [PW-1:0] p1;
      set_heads(2'b11, 5'd1, 5'd2, 5'd3, 5'd5, 5'd6, 5'd4);
      p0 = head_payload_i[0];
      p1 = head_payload_i[1];
      #1;
      checks++;
      if (read_num_o !== 2'd2) begin
         failures++;
         $display("FAIL pair_read_num got=%0d exp=2", read_num_o);
      end
      tick();
      checks++;
      if (issue_valid_o !== 2'b11 || issue_rd_o[0] !== 5'd3 || issue_rd_o[1] !== 5'd4) begin
         failures++;
         $display("FAIL pair_issue got valid=%b rd1=%0d rd0=%0d exp 11/4/3",
                  issue_valid_o, issue_rd_o[1], issue_rd_o[0]);
      end
      checks++;
      if (issue_payload_o[0] !== p0 || issue_payload_o[1] !== p1) begin
         failures++;
         $display("FAIL pair_payload got=%h exp=%h", issue_payload_o[0][31:0], p0[31:0]);
      end
      set_heads(2'b01, 5'd3, 5'd0, 5'd15, 5'd0, 5'd0, 5'd0);
      #1;
      checks++;
      if (read_num_o !== 2'd0) begin
         failures++;
         $display("FAIL pair_busy3 got=%0d exp=0", read_num_o);
      end
      set_heads(2'b01, 5'd0, 5'd4, 5'd15, 5'd0, 5'd0, 5'd0);
      #1;
      checks++;
      if (read_num_o !== 2'd0) begin
         failures++;
         $display("FAIL pair_busy4 got=%0d exp=0", read_num_o);
      end
      clear_state();
   endtask

   task automatic test_raw();
      set_heads(2'b11, 5'd1, 5'd2, 5'd7, 5'd7, 5'd0, 5'd10);
      #1;
      checks++;
      if (read_num_o !== 2'd1) begin
         failures++;
         $display("FAIL raw_read_num got=%0d exp=1", read_num_o);
      end
      tick();
      checks++;
      if (issue_valid_o !== 2'b01 || issue_rd_o[0] !== 5'd7) begin
         failures++;
         $display("FAIL raw_issue got valid=%b rd0=%0d exp 01/7", issue_valid_o, issue_rd_o[0]);
      end
      set_heads(2'b01, 5'd7, 5'd0, 5'd10, 5'd0, 5'd0, 5'd0);
      #1;
      checks++;
      if (read_num_o !== 2'd0) begin
         failures++;
         $display("FAIL raw_stall got=%0d exp=0", read_num_o);
      end
      tick();
      checks++;
      if (read_num_o !== 2'd0 || issue_valid_o !== 2'b00) begin
         failures++;
         $display("FAIL raw_stall2 got rn=%0d valid=%b exp 0/00", read_num_o, issue_valid_o);
      end
      wb_valid_i  = 2'b01;
      wb_reg_i[0] = 5'd7;
      #1;
      checks++;
      if (read_num_o !== 2'd1) begin
         failures++;
         $display("FAIL raw_bypass got=%0d exp=1", read_num_o);
      end
      tick();
      wb_valid_i = '0;
      checks++;
      if (issue_valid_o !== 2'b01 || issue_rd_o[0] !== 5'd10) begin
         failures++;
         $display("FAIL raw_reissue got valid=%b rd0=%0d exp 01/10", issue_valid_o, issue_rd_o[0]);
      end
      clear_state();
   endtask

   task automatic test_backpressure();
      set_heads(2'b11, 5'd1, 5'd2, 5'd11, 5'd1, 5'd2, 5'd12);
      tick();
      ex_ready_i = 1'b0;
      set_heads(2'b11, 5'd1, 5'd2, 5'd13, 5'd1, 5'd2, 5'd14);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (read_num_o !== 2'd0) begin
            failures++;
            $display("FAIL bp_read_num cyc=%0d got=%0d exp=0", i, read_num_o);
         end
         tick();
         checks++;
         if (issue_valid_o !== 2'b11 || issue_rd_o[0] !== 5'd11 || issue_rd_o[1] !== 5'd12) begin
            failures++;
            $display("FAIL bp_hold cyc=%0d got valid=%b rd=%0d/%0d exp 11/12/11",
                     i, issue_valid_o, issue_rd_o[1], issue_rd_o[0]);
         end
      end
      ex_ready_i = 1'b1;
      #1;
      checks++;
      if (read_num_o !== 2'd2) begin
         failures++;
         $display("FAIL bp_release got=%0d exp=2", read_num_o);
      end
      tick();
      checks++;
      if (issue_valid_o !== 2'b11 || issue_rd_o[0] !== 5'd13 || issue_rd_o[1] !== 5'd14) begin
         failures++;
         $display("FAIL bp_load got valid=%b rd=%0d/%0d exp 11/14/13",
                  issue_valid_o, issue_rd_o[1], issue_rd_o[0]);
      end
      clear_state();
   endtask

   task automatic test_r0();
      set_heads(2'b11, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0);
      #1;
      checks++;
      if (read_num_o !== 2'd2) begin
         failures++;
         $display("FAIL r0_pair got=%0d exp=2", read_num_o);
      end
      tick();
      set_heads(2'b11, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd2);
      #1;
      checks++;
      if (read_num_o !== 2'd2) begin
         failures++;
         $display("FAIL r0_not_busy got=%0d exp=2", read_num_o);
      end
      set_heads(2'b10, 5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd4);
      #1;
      checks++;
      if (read_num_o !== 2'd0) begin
         failures++;
         $display("FAIL illegal_hv got=%0d exp=0", read_num_o);
      end
      tick();
      checks++;
      if (issue_valid_o !== 2'b00) begin
         failures++;
         $display("FAIL illegal_hv_issue got=%b exp=00", issue_valid_o);
      end
      clear_state();
   endtask

   task automatic test_flush();
      set_heads(2'b01, 5'd1, 5'd2, 5'd5, 5'd0, 5'd0, 5'd0);
      tick();
      flush_i     = 1'b1;
      wb_valid_i  = 2'b01;
      wb_reg_i[0] = 5'd9;
      set_heads(2'b01, 5'd1, 5'd2, 5'd20, 5'd0, 5'd0, 5'd0);
      #1;
      checks++;
      if (read_num_o !== 2'd0) begin
         failures++;
         $display("FAIL flush_read_num got=%0d exp=0", read_num_o);
      end
      tick();
      flush_i    = 1'b0;
      wb_valid_i = '0;
      checks++;
      if (issue_valid_o !== 2'b00) begin
         failures++;
         $display("FAIL flush_valid got=%b exp=00", issue_valid_o);
      end
      set_heads(2'b01, 5'd5, 5'd0, 5'd21, 5'd0, 5'd0, 5'd0);
      #1;
      checks++;
      if (read_num_o !== 2'd1) begin
         failures++;
         $display("FAIL flush_sb_clear got=%0d exp=1", read_num_o);
      end
      clear_state();
   endtask

   task automatic test_collision();
      logic [31:0] cnt0;
      set_heads(2'b01, 5'd1, 5'd2, 5'd8, 5'd0, 5'd0, 5'd0);
      tick();
      set_heads(2'b01, 5'd1, 5'd2, 5'd8, 5'd0, 5'd0, 5'd0);
      #1;
      checks++;
      if (read_num_o !== 2'd0) begin
         failures++;
         $display("FAIL coll_waw got=%0d exp=0", read_num_o);
      end
      wb_valid_i  = 2'b10;
      wb_reg_i[1] = 5'd8;
      #1;
      checks++;
      if (read_num_o !== 2'd1) begin
         failures++;
         $display("FAIL coll_bypass got=%0d exp=1", read_num_o);
      end
      cnt0 = issue_cnt_o;
      tick();
      wb_valid_i = '0;
      checks++;
      if (issue_cnt_o !== (PERF ? cnt0 + 32'd1 : 32'd0)) begin
         failures++;
         $display("FAIL coll_issue_cnt got=%0d exp=%0d", issue_cnt_o,
                  PERF ? cnt0 + 32'd1 : 32'd0);
      end
      set_heads(2'b01, 5'd8, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
      #1;
      checks++;
      if (read_num_o !== 2'd0) begin
         failures++;
         $display("FAIL coll_set_wins got=%0d exp=0", read_num_o);
      end
      clear_state();
   endtask

   typedef struct {
      logic [4:0]    rs0;
      logic [4:0]    rs1;
      logic [4:0]    rd;
      logic [PW-1:0] pay;
   } ins_t;

   ins_t          q[$];
   logic [31:0]   mb;
   logic [1:0]    mv;
   logic [1:0][4:0]    mrd;
   logic [1:0][PW-1:0] mpay;
   logic [31:0]   ms;
   logic [31:0]   mi;

   function automatic bit eb(input logic [4:0] r);
      bit b;
      b = (r != 5'd0) && mb[r];
      for (int k = 0; k < WB; k++) begin
         if (wb_valid_i[k] && wb_reg_i[k] == r) b = 1'b0;
      end
      return b;
   endfunction

   task automatic test_random();
      int   n;
      int   exp_n;
      bit   acc;
      bit   g0;
      bit   g1;
      ins_t t;
      rst          = 1'b1;
      flush_i      = 1'b0;
      head_valid_i = 2'b00;
      wb_valid_i   = '0;
      ex_ready_i   = 1'b1;
      tick();
      rst = 1'b0;
      mb  = '0;
      mv  = '0;
      mrd = '0;
      mpay = '0;
      ms  = '0;
      mi  = '0;
      q.delete();
      repeat (3000) begin
         while (q.size() < 4) begin
            t.rs0 = 5'($urandom_range(0, 7));
            t.rs1 = 5'($urandom_range(0, 7));
            t.rd  = 5'($urandom_range(0, 7));
            t.pay = rnd_pay();
            q.push_back(t);
         end
         n = $urandom_range(0, 2);
         head_valid_i = (n == 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
         for (int s = 0; s < 2; s++) begin
            head_rs0_i[s]     = q[s].rs0;
            head_rs1_i[s]     = q[s].rs1;
            head_rd_i[s]      = q[s].rd;
            head_payload_i[s] = q[s].pay;
         end
         flush_i    = ($urandom_range(0, 19) == 0);
         ex_ready_i = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < WB; k++) begin
            wb_valid_i[k] = 1'($urandom_range(0, 1));
            wb_reg_i[k]   = 5'($urandom_range(0, 7));
         end
         #1;
         acc = (mv == 2'b00) || ex_ready_i;
         g0 = head_valid_i[0] && acc && !flush_i
              && !eb(q[0].rs0) && !eb(q[0].rs1) && !eb(q[0].rd);
         g1 = g0 && head_valid_i[1]
              && !eb(q[1].rs0) && !eb(q[1].rs1) && !eb(q[1].rd)
              && !(q[0].rd != 0 && (q[0].rd == q[1].rs0 || q[0].rd == q[1].rs1))
              && !(q[1].rd != 0 && q[1].rd == q[0].rd);
         exp_n = int'(g0) + int'(g1);
         checks++;
         if (read_num_o !== 2'(exp_n)) begin
            failures++;
            $display("FAIL rnd_read_num t=%0t got=%0d exp=%0d", $time, read_num_o, exp_n);
         end
         if (head_valid_i[0] && exp_n == 0 && !flush_i) ms = ms + 32'd1;
         mi = mi + 32'(exp_n);
         if (flush_i) begin
            mv = 2'b00;
            mb = '0;
         end else begin
            for (int k = 0; k < WB; k++) begin
               if (wb_valid_i[k]) mb[wb_reg_i[k]] = 1'b0;
            end
            if (acc) begin
               mv = {g1, g0};
               if (g0) begin
                  mrd[0]  = q[0].rd;
                  mpay[0] = q[0].pay;
               end
               if (g1) begin
                  mrd[1]  = q[1].rd;
                  mpay[1] = q[1].pay;
               end
            end
            if (g0 && q[0].rd != 0) mb[q[0].rd] = 1'b1;
            if (g1 && q[1].rd != 0) mb[q[1].rd] = 1'b1;
         end
         repeat (exp_n) void'(q.pop_front());
         tick();
         checks++;
         if (issue_valid_o !== mv) begin
            failures++;
            $display("FAIL rnd_valid t=%0t got=%b exp=%b", $time, issue_valid_o, mv);
         end
         for (int s = 0; s < 2; s++) begin
            if (mv[s]) begin
               checks++;
               if (issue_rd_o[s] !== mrd[s] || issue_payload_o[s] !== mpay[s]) begin
                  failures++;
                  $display("FAIL rnd_slot%0d t=%0t got rd=%0d exp rd=%0d",
                           s, $time, issue_rd_o[s], mrd[s]);
               end
            end
         end
         checks++;
         if (stall_cnt_o !== (PERF ? ms : 32'd0) || issue_cnt_o !== (PERF ? mi : 32'd0)) begin
            failures++;
            $display("FAIL rnd_counters t=%0t got=%0d/%0d exp=%0d/%0d", $time,
                     stall_cnt_o, issue_cnt_o, PERF ? ms : 32'd0, PERF ? mi : 32'd0);
         end
      end
      flush_i      = 1'b0;
      head_valid_i = 2'b00;
   endtask

   initial begin
      test_reset();
      test_pair();
      test_raw();
      test_backpressure();
      test_r0();
      test_flush();
      test_collision();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
